ultrasonic_sensor_scheduler: RTL and testbench

Time-multiplexes one echo-measurement channel across NUM_SENSORS_P HC-SR04 sensors. Round-robin over enabled sensors: per slot it fires that sensor's trigger, muxes and synchronises its echo, measures echo high time in microseconds with rise/length timeouts, and emits a tagged result. Sits between the sensor pins and the distance converter / UART path.

---
 rtl/ultrasonic_sensor_pkg.sv | 26 ++
 rtl/ultrasonic_sensor_us_tick.sv | 27 ++
 rtl/ultrasonic_sensor_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_ultrasonic_sensor_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_sensor_pkg.sv
// ultrasonic_sensor_pkg: shared state encoding, result status codes and default timing for the sensor scheduler
package ultrasonic_sensor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        TRIG,
        WAIT_RISE,
        MEASURE,
        REPORT,
        GAP
    } state_e;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_NO_RISE  = 2'b01;
    localparam logic [1:0] ST_TOO_LONG = 2'b10;

    localparam int NUM_SENSORS_DEF  = 4;
    localparam int US_DIV_DEF       = 50;
    localparam int TRIG_US_DEF      = 10;
    localparam int RISE_TIMEOUT_DEF = 2000;
    localparam int ECHO_MAX_DEF     = 38000;
    localparam int SLOT_US_DEF      = 60000;
    localparam int WIDTH_W_DEF      = 16;

endpackage

// File: rtl/ultrasonic_sensor_us_tick.sv
// ultrasonic_sensor_us_tick: microsecond prescaler with synchronous restart, tick and one-cycle-early pre-tick
module ultrasonic_sensor_us_tick #(
    parameter int DIV_P = 50
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic tick_o,
    output logic pre_tick_o
);

    localparam int CW = DIV_P > 1 ? $clog2(DIV_P) : 1;

    logic [CW-1:0] cnt_q;

    assign tick_o     = cnt_q == CW'(DIV_P - 1);
    assign pre_tick_o = (DIV_P == 1) || (cnt_q == CW'(DIV_P - 2));

    // Count 0..DIV_P-1, wrapping on the tick; restart realigns the count to the slot start
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= (restart_i || tick_o) ? '0 : cnt_q + 1'b1;
    end

endmodule

// File: rtl/ultrasonic_sensor_scheduler.sv
// ultrasonic_sensor_scheduler: round-robin trigger/echo timing of several HC-SR04 sensors on one measurement channel
module ultrasonic_sensor_scheduler
    import ultrasonic_sensor_pkg::*;
#(
    parameter int NUM_SENSORS_P     = NUM_SENSORS_DEF,
    parameter int ID_W_P            = 2,
    parameter int US_DIV_P          = US_DIV_DEF,
    parameter int TRIG_US_P         = TRIG_US_DEF,
    parameter int RISE_TIMEOUT_US_P = RISE_TIMEOUT_DEF,
    parameter int ECHO_MAX_US_P     = ECHO_MAX_DEF,
    parameter int SLOT_US_P         = SLOT_US_DEF,
    parameter int WIDTH_W_P         = WIDTH_W_DEF
) (
    input  logic                     Clk_i,
    input  logic                     Reset_i,
    input  logic                     Switch_i,
    input  logic [NUM_SENSORS_P-1:0] Enable_mask_i,
    input  logic [NUM_SENSORS_P-1:0] Echo_i,
    output logic [NUM_SENSORS_P-1:0] Trig_o,
    output logic                     Result_valid_o,
    output logic [ID_W_P-1:0]        Result_id_o,
    output logic [WIDTH_W_P-1:0]     Result_width_o,
    output logic [1:0]               Result_status_o,
    output logic                     Busy_o
);

    localparam int CNT_W  = $clog2((RISE_TIMEOUT_US_P > TRIG_US_P ? RISE_TIMEOUT_US_P : TRIG_US_P) + 1);
    localparam int SLOT_W = $clog2(SLOT_US_P + 1);

    state_e               state_q, state_d;
    logic [ID_W_P-1:0]    idx_q, idx_d, idx_nxt, cand;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH_W_P-1:0] width_q, width_d;
    logic [SLOT_W-1:0]    slot_q;
    logic [2:0]           sync_q;
    logic [ID_W_P-1:0]    res_id_q, res_id_d;
    logic [WIDTH_W_P-1:0] res_width_q, res_width_d;
    logic [1:0]           res_status_q, res_status_d;
    logic                 tick, pre_tick, restart, rise, fall, slot_done;

    // SELECT always leads into TRIG, so restarting there aligns every us count to the trigger start
    assign restart = state_q == SELECT;
    assign rise    = sync_q[1] & ~sync_q[2];
    assign fall    = ~sync_q[1] & sync_q[2];
    // GAP hands over one cycle before the final tick so the SELECT cycle closes the slot and
    // trigger starts land exactly SLOT_US_P us apart
    assign slot_done = (slot_q == SLOT_W'(SLOT_US_P)) ||
                       ((slot_q == SLOT_W'(SLOT_US_P - 1)) && pre_tick);

    ultrasonic_sensor_us_tick #(.DIV_P(US_DIV_P)) u_us_tick (
        .clk_i      (Clk_i),
        .rst_i      (Reset_i),
        .restart_i  (restart),
        .tick_o     (tick),
        .pre_tick_o (pre_tick)
    );

    // Two-flop synchroniser on the selected echo plus a history flop for edge detection
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i)
            sync_q <= '0;
        else
            sync_q <= {sync_q[1:0], Echo_i[idx_q]};
    end

    // Slot length in us since trigger start, saturating
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i)
            slot_q <= '0;
        else if (restart)
            slot_q <= '0;
        else if (tick && slot_q != SLOT_W'(SLOT_US_P))
            slot_q <= slot_q + 1'b1;
    end

    // Next enabled sensor after the current one; the nearest candidate is applied last so it wins
    always_comb begin
        idx_nxt = idx_q;
        cand    = idx_q;
        for (int k = NUM_SENSORS_P; k >= 1; k--) begin
            cand = ID_W_P'((int'(idx_q) + k) % NUM_SENSORS_P);
            if (Enable_mask_i[cand])
                idx_nxt = cand;
        end
    end

    // State register
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Datapath registers: sensor index, us counters and the held result
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            idx_q        <= ID_W_P'(NUM_SENSORS_P - 1);
            cnt_q        <= '0;
            width_q      <= '0;
            res_id_q     <= '0;
            res_width_q  <= '0;
            res_status_q <= '0;
        end else begin
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            width_q      <= width_d;
            res_id_q     <= res_id_d;
            res_width_q  <= res_width_d;
            res_status_q <= res_status_d;
        end
    end

    // Next-state and datapath update; echo edges are tested before timeout ticks so edges win
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        width_d      = width_q;
        res_id_d     = res_id_q;
        res_width_d  = res_width_q;
        res_status_d = res_status_q;
        case (state_q)
            IDLE:
                if (Switch_i && |Enable_mask_i)
                    state_d = SELECT;
            SELECT: begin
                idx_d   = idx_nxt;
                cnt_d   = '0;
                state_d = TRIG;
            end
            TRIG:
                if (tick) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(TRIG_US_P - 1)) begin
                        cnt_d   = '0;
                        state_d = WAIT_RISE;
                    end
                end
            WAIT_RISE:
                if (rise) begin
                    width_d = '0;
                    state_d = MEASURE;
                end else if (tick) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(RISE_TIMEOUT_US_P - 1)) begin
                        res_id_d     = idx_q;
                        res_width_d  = '0;
                        res_status_d = ST_NO_RISE;
                        state_d      = REPORT;
                    end
                end
            MEASURE:
                if (fall) begin
                    res_id_d     = idx_q;
                    res_width_d  = width_q;
                    res_status_d = ST_OK;
                    state_d      = REPORT;
                end else if (tick) begin
                    width_d = width_q + 1'b1;
                    if (width_q == WIDTH_W_P'(ECHO_MAX_US_P - 1)) begin
                        res_id_d     = idx_q;
                        res_width_d  = WIDTH_W_P'(ECHO_MAX_US_P);
                        res_status_d = ST_TOO_LONG;
                        state_d      = REPORT;
                    end
                end
            REPORT:
                state_d = GAP;
            GAP:
                if (slot_done)
                    state_d = (Switch_i && |Enable_mask_i) ? SELECT : IDLE;
            default:
                state_d = IDLE;
        endcase
    end

    // Outputs decoded from the registered state so reset clears the trigger immediately
    always_comb begin
        Trig_o          = (state_q == TRIG) ? {{(NUM_SENSORS_P-1){1'b0}}, 1'b1} << idx_q : '0;
        Result_valid_o  = state_q == REPORT;
        Busy_o          = state_q != IDLE;
        Result_id_o     = res_id_q;
        Result_width_o  = res_width_q;
        Result_status_o = res_status_q;
    end

endmodule

// File: tb/tb_ultrasonic_sensor_scheduler.sv
// tb_ultrasonic_sensor_scheduler: randomized self-checking bench with sensor echo models and a result/timing reference model
module tb_ultrasonic_sensor_scheduler;

    localparam int N    = 4;
    localparam int DIV  = 2;
    localparam int TRIG = 3;
    localparam int RISE = 20;
    localparam int EMAX = 50;
    localparam int SLOT = 100;

    typedef struct {
        int id;
        int w;
        int st;
    } exp_t;

    logic          Clk_i = 1'b0;
    logic          Reset_i = 1'b1;
    logic          Switch_i = 1'b0;
    logic [N-1:0]  Enable_mask_i = '0;
    logic [N-1:0]  Trig_o;
    logic          Result_valid_o;
    logic [1:0]    Result_id_o;
    logic [15:0]   Result_width_o;
    logic [1:0]    Result_status_o;
    logic          Busy_o;
    logic          echo_pin [N];
    logic [N-1:0]  echo_bus;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   trig_start = 0;
    int   trig_end = 0;
    int   trig_starts = 0;
    int   res_cnt = 0;
    int   exp_last = N - 1;
    bit   cont = 0;
    bit   rand_mode = 0;
    int   cfg_us [N] = '{10, 20, 30, 40};
    int   wid_us [N] = '{0, 0, 0, 0};
    logic [N-1:0] trig_prev = '0;
    exp_t expq [$];

    assign echo_bus = {echo_pin[3], echo_pin[2], echo_pin[1], echo_pin[0]};

    ultrasonic_sensor_scheduler #(
        .NUM_SENSORS_P     (N),
        .ID_W_P            (2),
        .US_DIV_P          (DIV),
        .TRIG_US_P         (TRIG),
        .RISE_TIMEOUT_US_P (RISE),
        .ECHO_MAX_US_P     (EMAX),
        .SLOT_US_P         (SLOT),
        .WIDTH_W_P         (16)
    ) dut (
        .Clk_i           (Clk_i),
        .Reset_i         (Reset_i),
        .Switch_i        (Switch_i),
        .Enable_mask_i   (Enable_mask_i),
        .Echo_i          (echo_bus),
        .Trig_o          (Trig_o),
        .Result_valid_o  (Result_valid_o),
        .Result_id_o     (Result_id_o),
        .Result_width_o  (Result_width_o),
        .Result_status_o (Result_status_o),
        .Busy_o          (Busy_o)
    );

    always #5 Clk_i = ~Clk_i;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pick_width();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 0;
        if (r < 7) return $urandom_range(1, 45);
        return $urandom_range(55, 80);
    endfunction

    // Sensor models: 5 us after the trigger falls, echo high for the configured width (0 = silent)
    for (genvar g = 0; g < N; g++) begin : g_sensor
        initial begin
            int w;
            echo_pin[g] = 1'b0;
            forever begin
                @(negedge Trig_o[g]);
                w = wid_us[g];
                if (w > 0) begin
                    repeat (5 * DIV) @(negedge Clk_i);
                    echo_pin[g] = 1'b1;
                    repeat (w * DIV) @(negedge Clk_i);
                    echo_pin[g] = 1'b0;
                end
            end
        end
    end

    // Reference model and monitor, sampled 1 time unit after each rising edge
    always @(posedge Clk_i) begin
        int   id;
        int   nxt;
        int   w;
        int   ow;
        exp_t e;
        #1;
        cyc++;
        if (Reset_i) begin
            exp_last  = N - 1;
            cont      = 0;
            trig_prev = '0;
            expq.delete();
        end else begin
            if (Trig_o != '0 && trig_prev == '0) begin
                check("trig_onehot", int'($onehot(Trig_o)), 1);
                id = 0;
                for (int i = 0; i < N; i++)
                    if (Trig_o[i]) id = i;
                nxt = -1;
                for (int k = 1; k <= N && nxt < 0; k++)
                    if (Enable_mask_i[(exp_last + k) % N]) nxt = (exp_last + k) % N;
                check("trig_id", id, nxt);
                if (nxt >= 0) exp_last = nxt;
                if (cont) check("slot_period", cyc - trig_start, SLOT * DIV);
                cont       = 1;
                trig_start = cyc;
                trig_starts++;
                w = rand_mode ? pick_width() : cfg_us[id];
                wid_us[id] = w;
                e.id = id;
                e.w  = (w == 0) ? 0 : (w >= EMAX ? EMAX : w);
                e.st = (w == 0) ? 1 : (w >= EMAX ? 2 : 0);
                expq.push_back(e);
            end
            if (Trig_o == '0 && trig_prev != '0) begin
                check("trig_len", cyc - trig_start, TRIG * DIV);
                trig_end = cyc;
            end
            if (Result_valid_o) begin
                res_cnt++;
                if (expq.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check("res_id", int'(Result_id_o), e.id);
                    check("res_status", int'(Result_status_o), e.st);
                    ow = int'(Result_width_o);
                    if (e.st == 0 && ow >= e.w - 1 && ow <= e.w + 1) ow = e.w;
                    check("res_width", ow, e.w);
                    if (e.st == 1) check("norise_delay", cyc - trig_end, RISE * DIV);
                    if (e.st == 2) check("toolong_before_fall", int'(echo_bus[Result_id_o]), 1);
                end
            end
            if (!Busy_o) cont = 0;
            trig_prev = Trig_o;
        end
    end

    task automatic wait_results(input int n);
        int tgt;
        int t;
        tgt = res_cnt + n;
        t   = 0;
        while (res_cnt < tgt && t < n * 300 + 500) begin
            @(negedge Clk_i);
            t++;
        end
        check("result_timeout", int'(res_cnt >= tgt), 1);
    endtask

    task automatic wait_trig();
        int tgt;
        int t;
        tgt = trig_starts + 1;
        t   = 0;
        while (trig_starts < tgt && t < 500) begin
            @(negedge Clk_i);
            t++;
        end
        check("trig_timeout", int'(trig_starts >= tgt), 1);
    endtask

    initial begin
        int n0;
        int t;
        repeat (3) @(negedge Clk_i);
        check("rst_trig", int'(Trig_o), 0);
        check("rst_valid", int'(Result_valid_o), 0);
        check("rst_busy", int'(Busy_o), 0);
        check("rst_id", int'(Result_id_o), 0);
        check("rst_width", int'(Result_width_o), 0);
        check("rst_status", int'(Result_status_o), 0);
        Reset_i       = 1'b0;
        Enable_mask_i = 4'b1111;
        Switch_i      = 1'b1;
        wait_results(4);
        Enable_mask_i = 4'b0101;
        wait_results(4);
        wait_trig();
        Enable_mask_i = 4'b1000;
        wait_results(2);
        Enable_mask_i = 4'b1111;
        cfg_us = '{15, 0, 25, 35};
        wait_results(4);
        cfg_us = '{12, 22, 80, 33};
        wait_results(4);
        rand_mode = 1;
        repeat (12) begin
            wait_trig();
            Enable_mask_i = N'($urandom_range(1, 15));
        end
        rand_mode     = 0;
        cfg_us        = '{30, 30, 30, 30};
        Enable_mask_i = 4'b1111;
        wait_results(2);
        t = 0;
        while (echo_bus == '0 && t < 500) begin
            @(negedge Clk_i);
            t++;
        end
        check("echo_timeout", int'(echo_bus != '0), 1);
        repeat (4) @(negedge Clk_i);
        Switch_i = 1'b0;
        wait_results(1);
        t = 0;
        while (Busy_o && t < 600) begin
            @(negedge Clk_i);
            t++;
        end
        check("stop_busy", int'(Busy_o), 0);
        n0 = trig_starts;
        repeat (300) @(negedge Clk_i);
        check("stop_no_trig", trig_starts - n0, 0);
        Switch_i = 1'b1;
        wait_results(1);
        cfg_us = '{0, 0, 0, 0};
        wait_trig();
        repeat (2) @(negedge Clk_i);
        Reset_i = 1'b1;
        #1;
        check("midrst_trig", int'(Trig_o), 0);
        check("midrst_valid", int'(Result_valid_o), 0);
        check("midrst_busy", int'(Busy_o), 0);
        check("midrst_id", int'(Result_id_o), 0);
        check("midrst_width", int'(Result_width_o), 0);
        check("midrst_status", int'(Result_status_o), 0);
        repeat (2) @(negedge Clk_i);
        Reset_i = 1'b0;
        wait_trig();
        check("post_rst_trig", int'(Trig_o), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
